// File: rtl/noc_port_packet_checker.sv
// Per-port NoC packet checker: frames the flit stream of one router output
// port into packets, validates each header, detects stalled packets and
// records the first violation in sticky capture registers.
module noc_port_packet_checker #(
  parameter int unsigned FLIT_W     = 64,
  parameter logic [7:0]  MAX_X      = 8'd1,
  parameter logic [7:0]  MAX_Y      = 8'd0,
  parameter logic [7:0]  MAX_LEN    = 8'd22,
  parameter logic [15:0] TIMEOUT    = 16'd1024,
  parameter logic        OFFCHIP_OK = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [13:0]       my_chipid,
  input  logic              flit_valid,
  input  logic [FLIT_W-1:0] flit_data,
  input  logic              err_clear,
  output logic              in_packet,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [2:0]        err_code,
  output logic [FLIT_W-1:0] err_header,
  output logic [31:0]       pkt_count,
  output logic [31:0]       flit_count
);

  localparam logic [0:0] ST_HDR  = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_X    = 3'd1;
  localparam logic [2:0] CODE_Y    = 3'd2;
  localparam logic [2:0] CODE_LEN  = 3'd3;
  localparam logic [2:0] CODE_TMO  = 3'd4;

  logic [0:0]        state;
  logic [7:0]        remaining;
  logic [15:0]       idle;
  logic [FLIT_W-1:0] cur_hdr;

  logic [13:0]       hdr_chip;
  logic [7:0]        hdr_x;
  logic [7:0]        hdr_y;
  logic [7:0]        hdr_len;
  logic              skip_xy;
  logic [2:0]        hdr_code;
  logic              timeout;
  logic              take_hdr;
  logic [2:0]        det_code;
  logic [FLIT_W-1:0] det_hdr;

  assign hdr_chip = flit_data[63:50];
  assign hdr_x    = flit_data[49:42];
  assign hdr_y    = flit_data[41:34];
  assign hdr_len  = flit_data[29:22];

  // Header legality check, highest-priority violation only.
  always_comb begin
    skip_xy  = OFFCHIP_OK && (hdr_chip != my_chipid);
    hdr_code = CODE_NONE;
    if (!skip_xy && (hdr_x > MAX_X))
      hdr_code = CODE_X;
    else if (!skip_xy && (hdr_y > MAX_Y))
      hdr_code = CODE_Y;
    else if (hdr_len > MAX_LEN)
      hdr_code = CODE_LEN;
  end

  // A stalled packet is abandoned in the same cycle it is detected, so a flit
  // arriving then is parsed as a fresh header; the timeout code wins the pulse.
  always_comb begin
    timeout  = (state == ST_BODY) && (idle == TIMEOUT);
    take_hdr = flit_valid && ((state == ST_HDR) || timeout);
    det_code = CODE_NONE;
    det_hdr  = flit_data;
    if (timeout) begin
      det_code = CODE_TMO;
      det_hdr  = cur_hdr;
    end else if (take_hdr) begin
      det_code = hdr_code;
    end
  end

  // Packet framing FSM with idle watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_HDR;
      remaining <= '0;
      idle      <= '0;
      cur_hdr   <= '0;
    end else if (take_hdr) begin
      cur_hdr <= flit_data;
      idle    <= '0;
      if (hdr_len != 8'd0) begin
        state     <= ST_BODY;
        remaining <= hdr_len;
      end else begin
        state     <= ST_HDR;
        remaining <= '0;
      end
    end else if (timeout) begin
      state     <= ST_HDR;
      remaining <= '0;
      idle      <= '0;
    end else if (state == ST_BODY) begin
      if (flit_valid) begin
        remaining <= remaining - 8'd1;
        idle      <= '0;
        if (remaining == 8'd1)
          state <= ST_HDR;
      end else if (idle != '1) begin
        idle <= idle + 16'd1;
      end
    end
  end

  assign in_packet = (state == ST_BODY);

  // Error pulse and first-error-wins capture; a coinciding clear lets the new error in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_code   <= '0;
      err_header <= '0;
    end else begin
      err_pulse <= (det_code != CODE_NONE);
      if (det_code != CODE_NONE) begin
        if (!err_sticky || err_clear) begin
          err_code   <= det_code;
          err_header <= det_hdr;
        end
        err_sticky <= 1'b1;
      end else if (err_clear) begin
        err_sticky <= 1'b0;
        err_code   <= '0;
        err_header <= '0;
      end
    end
  end

  // Saturating packet and flit counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count  <= '0;
      flit_count <= '0;
    end else begin
      if (take_hdr && (pkt_count != '1))
        pkt_count <= pkt_count + 32'd1;
      if (flit_valid && (flit_count != '1))
        flit_count <= flit_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_noc_port_packet_checker.sv
// Scoreboard bench for noc_port_packet_checker: a packet-level reference
// model predicts framing, counters and error captures; a monitor process
// matches every err_pulse against the queued expectations.
module tb_noc_port_packet_checker;

  localparam int TMO     = 1024;
  localparam int LIM_X   = 1;
  localparam int LIM_Y   = 0;
  localparam int LIM_LEN = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] my_chipid = '0;
  logic        flit_valid = 1'b0;
  logic [63:0] flit_data = '0;
  logic        err_clear = 1'b0;
  logic        in_packet, err_pulse, err_sticky;
  logic [2:0]  err_code;
  logic [63:0] err_header;
  logic [31:0] pkt_count, flit_count;

  logic        oc_valid = 1'b0;
  logic [63:0] oc_data = '0;
  logic        oc_in_packet, oc_err_pulse, oc_err_sticky;
  logic [2:0]  oc_err_code;
  logic [63:0] oc_err_header;
  logic [31:0] oc_pkt_count, oc_flit_count;

  int total = 0;
  int bad = 0;
  int ncyc = 0;

  typedef struct {
    int          due;
    logic [2:0]  code;
    logic [63:0] hdr;
  } exp_t;
  exp_t sb[$];

  // reference model state
  bit          m_inpkt;
  int          m_rem, m_idle;
  logic [63:0] m_hdr;
  bit          m_sticky;
  logic [2:0]  m_code;
  logic [63:0] m_caphdr;
  longint      m_pkt, m_flit;

  noc_port_packet_checker #(.FLIT_W(64), .OFFCHIP_OK(1'b0)) dut (
    .clk(clk), .rst(rst), .my_chipid(my_chipid), .flit_valid(flit_valid),
    .flit_data(flit_data), .err_clear(err_clear), .in_packet(in_packet),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_code(err_code),
    .err_header(err_header), .pkt_count(pkt_count), .flit_count(flit_count)
  );

  noc_port_packet_checker #(.FLIT_W(64), .OFFCHIP_OK(1'b1)) dut_oc (
    .clk(clk), .rst(rst), .my_chipid(my_chipid), .flit_valid(oc_valid),
    .flit_data(oc_data), .err_clear(1'b0), .in_packet(oc_in_packet),
    .err_pulse(oc_err_pulse), .err_sticky(oc_err_sticky), .err_code(oc_err_code),
    .err_header(oc_err_header), .pkt_count(oc_pkt_count), .flit_count(oc_flit_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=%h req=%h (cycle %0d)", name, act, req, ncyc);
    end
  endtask

  function automatic logic [63:0] mkhdr(input logic [13:0] chip, input logic [7:0] x,
                                        input logic [7:0] y, input logic [7:0] len);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[63:50] = chip;
    h[49:42] = x;
    h[41:34] = y;
    h[29:22] = len;
    return h;
  endfunction

  task automatic model_reset();
    m_inpkt = 0; m_rem = 0; m_idle = 0; m_hdr = '0;
    m_sticky = 0; m_code = '0; m_caphdr = '0; m_pkt = 0; m_flit = 0;
    sb.delete();
  endtask

  // Packet-level prediction for one cycle of input.
  task automatic model_update(input logic v, input logic [63:0] d, input logic clr);
    int          e;
    logic [63:0] eh;
    int          x, y, len;
    e = 0;
    eh = '0;
    if (m_inpkt && m_idle == TMO) begin
      e = 4; eh = m_hdr;
      m_inpkt = 0; m_rem = 0; m_idle = 0;
    end
    if (v) m_flit++;
    if (m_inpkt) begin
      if (v) begin
        m_rem--; m_idle = 0;
        if (m_rem == 0) m_inpkt = 0;
      end else begin
        m_idle++;
      end
    end else if (v) begin
      m_pkt++;
      m_hdr = d;
      x = int'(d[49:42]); y = int'(d[41:34]); len = int'(d[29:22]);
      if (e == 0) begin
        if (x > LIM_X) e = 1;
        else if (y > LIM_Y) e = 2;
        else if (len > LIM_LEN) e = 3;
        eh = d;
      end
      if (len > 0) begin
        m_inpkt = 1; m_rem = len; m_idle = 0;
      end
    end
    if (e != 0) begin
      exp_t x_e;
      if (!m_sticky || clr) begin
        m_code = 3'(e); m_caphdr = eh;
      end
      m_sticky = 1;
      x_e.due = ncyc + 1; x_e.code = m_code; x_e.hdr = m_caphdr;
      sb.push_back(x_e);
    end else if (clr) begin
      m_sticky = 0; m_code = '0; m_caphdr = '0;
    end
  endtask

  task automatic step(input logic v, input logic [63:0] d, input logic clr);
    @(negedge clk);
    flit_valid = v; flit_data = d; err_clear = clr;
    model_update(v, d, clr);
    @(posedge clk);
    #1;
    chk("in_packet", 64'(in_packet), 64'(m_inpkt));
    chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
    chk("err_code", 64'(err_code), 64'(m_code));
    chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
    chk("flit_count", 64'(flit_count), 64'(m_flit));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, {$urandom, $urandom}, 1'b0);
  endtask

  task automatic send_packet(input logic [63:0] h, input int gaps);
    int len;
    len = int'(h[29:22]);
    step(1'b1, h, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (gaps != 0 && $urandom_range(0, 3) == 0)
        idle_cycles(int'($urandom_range(1, 2)));
      step(1'b1, {$urandom, $urandom}, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_packet"}, 64'(in_packet), 64'd0);
    chk({tag, "_err_pulse"}, 64'(err_pulse), 64'd0);
    chk({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
    chk({tag, "_err_code"}, 64'(err_code), 64'd0);
    chk({tag, "_err_header"}, err_header, 64'd0);
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
    chk({tag, "_flit_count"}, 64'(flit_count), 64'd0);
  endtask

  // Monitor: every err_pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (err_pulse) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL pulse_unexpected: act=err_pulse=1 req=no pulse (cycle %0d)", ncyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.due != ncyc || err_code !== e.code || err_header !== e.hdr) begin
              bad++;
              $display("FAIL pulse_match: act cyc=%0d code=%0d hdr=%h req cyc=%0d code=%0d hdr=%h",
                       ncyc, err_code, err_header, e.due, e.code, e.hdr);
            end
          end
        end else if (sb.size() > 0 && sb[0].due <= ncyc) begin
          exp_t e;
          e = sb.pop_front();
          total++;
          bad++;
          $display("FAIL pulse_missing: act=no pulse req=pulse code=%0d at cycle %0d", e.code, e.due);
        end
      end
    end
  end

  initial begin
    logic [63:0] h;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // clean packet: header + 2 body flits
    send_packet(mkhdr(14'd0, 8'd1, 8'd0, 8'd2), 0);
    idle_cycles(2);
    chk("clean_pkt_count", 64'(pkt_count), 64'd1);
    chk("clean_flit_count", 64'(flit_count), 64'd3);
    chk("clean_no_sticky", 64'(err_sticky), 64'd0);

    // dest-x error, then length error that must not override the capture
    h = mkhdr(14'd0, 8'd2, 8'd1, 8'd0);
    step(1'b1, h, 1'b0);
    idle_cycles(1);
    chk("destx_code", 64'(err_code), 64'd1);
    chk("destx_header", err_header, h);
    send_packet(mkhdr(14'd0, 8'd0, 8'd0, 8'd30), 0);
    idle_cycles(2);
    chk("len_after_destx_code", 64'(err_code), 64'd1);
    chk("len_after_destx_header", err_header, h);

    // off-chip header: legal only on the OFFCHIP_OK instance
    step(1'b0, '0, 1'b1);
    h = mkhdr(14'h1, 8'd5, 8'd0, 8'd0);
    oc_valid = 1'b1; oc_data = h;
    step(1'b1, h, 1'b0);
    oc_valid = 1'b0;
    idle_cycles(1);
    chk("offchip_ok_sticky", 64'(oc_err_sticky), 64'd0);
    chk("offchip_ok_code", 64'(oc_err_code), 64'd0);
    chk("offchip_ok_pkt", 64'(oc_pkt_count), 64'd1);
    chk("offchip_strict_code", 64'(err_code), 64'd1);

    // stall: len 3, one body flit, then TMO idle cycles
    step(1'b0, '0, 1'b1);
    h = mkhdr(14'd0, 8'd0, 8'd0, 8'd3);
    step(1'b1, h, 1'b0);
    step(1'b1, {$urandom, $urandom}, 1'b0);
    idle_cycles(TMO);
    chk("stall_still_in_packet", 64'(in_packet), 64'd1);
    step(1'b1, mkhdr(14'd0, 8'd0, 8'd0, 8'd0), 1'b0);
    chk("timeout_in_packet", 64'(in_packet), 64'd0);
    idle_cycles(1);
    chk("timeout_code", 64'(err_code), 64'd4);
    chk("timeout_header", err_header, h);

    // clear coinciding with a length error
    step(1'b1, mkhdr(14'd0, 8'd0, 8'd0, 8'd40), 1'b1);
    chk("clr_coincide_sticky", 64'(err_sticky), 64'd1);
    chk("clr_coincide_code", 64'(err_code), 64'd3);
    for (int i = 0; i < 40; i++) step(1'b1, {$urandom, $urandom}, 1'b0);

    // randomized traffic
    for (int p = 0; p < 300; p++) begin
      logic [7:0] len;
      len = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(18, 30));
      if ($urandom_range(0, 19) == 0) step(1'b0, '0, 1'b1);
      send_packet(mkhdr(14'($urandom), 8'($urandom_range(0, 2)), 8'($urandom_range(0, 1)), len), 1);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(3);

    // reset in the middle of a packet with 5 flits outstanding
    step(1'b1, mkhdr(14'd0, 8'd0, 8'd0, 8'd10), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'b0);
    chk("pre_reset_in_packet", 64'(in_packet), 64'd1);
    @(negedge clk);
    flit_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, mkhdr(14'd0, 8'd0, 8'd0, 8'd0), 1'b0);
    idle_cycles(2);
    chk("post_reset_pkt_count", 64'(pkt_count), 64'd1);
    chk("post_reset_sticky", 64'(err_sticky), 64'd0);
    chk("post_reset_in_packet", 64'(in_packet), 64'd0);

    idle_cycles(2);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_port_packet_checker.md
Name: noc_port_packet_checker

Overview:
- Synthesizable per-port checker that sits directly on one router output port (valid/data pair, one NoC) as the consumer of the port's flit stream.
- Frames flits into packets, decodes each header and flags illegal destinations, over-long packets and stalled packets.
- Records the first violation in sticky capture registers and keeps saturating flit and packet counters.
- Gives the network monitor a registered, single-signal error source per port, replacing per-cycle polling of every valid line.

Parameters:
- FLIT_W, 64, flit width in bits.
- MAX_X, 1, largest legal destination x coordinate.
- MAX_Y, 0, largest legal destination y coordinate.
- MAX_LEN, 8'd22, largest legal payload length in flits.
- TIMEOUT, 16'd1024, maximum idle cycles allowed between flits of one packet.
- OFFCHIP_OK, 1'b0, 1 = a header whose chipid differs from my_chipid is legal regardless of x/y (tile 0 off-chip exception).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- my_chipid  in  14  local chip id, quasi-static
- flit_valid  in  1  flit present on the port this cycle
- flit_data  in  FLIT_W  flit; header fields are chipid [63:50], x [49:42], y [41:34], len [29:22], msgtype [21:14]
- err_clear  in  1  clears sticky error state
- in_packet  out  1  1 while body flits are outstanding
- err_pulse  out  1  one-cycle pulse per detected violation
- err_sticky  out  1  set on first violation, held until cleared
- err_code  out  3  captured code: 0 none, 1 dest-x, 2 dest-y, 3 length, 4 timeout
- err_header  out  FLIT_W  header flit of the offending packet
- pkt_count  out  32  headers seen, saturating
- flit_count  out  32  valid flits seen, saturating

Behaviour:
- Reset (async assert, sync release): state = HDR, remaining = 0, idle counter = 0, all outputs 0.
- Every valid cycle is one transferred flit. Credit return is not observed.
- FSM HDR:
  - On flit_valid, latch the header into the current-header register and increment pkt_count.
  - If len == 0, stay in HDR. Otherwise remaining = len and go to BODY.
- FSM BODY:
  - Each flit_valid decrements remaining and clears the idle counter.
  - When remaining reaches 1 and a flit arrives, return to HDR.
  - Each cycle without flit_valid increments the idle counter. When it reaches TIMEOUT, raise a timeout error, force HDR and clear remaining.
  - A flit arriving in that same cycle is treated as a header.
- in_packet = (state == BODY), registered.
- Header checks are evaluated on the header cycle; the result is registered, so err_pulse asserts exactly one cycle after the header flit.
  - If chipid != my_chipid and OFFCHIP_OK = 1, the x/y checks are skipped.
  - Priority when several checks fail: dest-x (x > MAX_X) > dest-y (y > MAX_Y) > length (len > MAX_LEN).
  - Only the highest-priority code is reported.
  - Framing still follows len even when the length error fires.
- Timeout errors: err_pulse asserts the cycle after the idle counter hits TIMEOUT; err_header = the latched current header.
- Capture: err_code and err_header load only when err_sticky is 0 (first error wins); err_sticky then sets. Later errors pulse err_pulse but change no captured value.
- err_clear: clears err_sticky, err_code and err_header next cycle. If err_clear coincides with a new error, the new error is captured and err_sticky stays 1.
- Counters: 32-bit, stop at 32'hFFFF_FFFF; they are not cleared by err_clear.
- Arithmetic: comparisons are unsigned on 8-bit fields; remaining is 8 bits; the idle counter is 16 bits and saturating.
- Reset mid-packet discards framing; the next valid flit is treated as a header.

Test Plan:
- Header x = 1, y = 0, len = 2, then 2 body flits → no err_pulse; pkt_count = 1, flit_count = 3; in_packet high for exactly 2 cycles after the header.
- Header x = 2, y = 1 → err_pulse 1 cycle later, err_code = 1, err_header = that flit; a following header with len = 30 pulses err_pulse but err_code stays 1.
- OFFCHIP_OK = 1, header chipid = 14'h1, my_chipid = 0, x = 5 → no error; with OFFCHIP_OK = 0 → err_code = 1.
- Header len = 3, one body flit, then 1024 idle cycles → err_code = 4, in_packet drops; next flit is parsed as a header (pkt_count increments).
- Assert err_clear in the same cycle a len = 40 header error registers → err_sticky remains 1, err_code = 3.
- Assert rst during BODY with remaining = 5 → all outputs 0 immediately; the first flit after release with x = 0, len = 0 counts as pkt_count = 1, no error.
